block_reassembler: RTL and testbench
====================================

# block_reassembler

Downstream stage of the per-block watermark processor. Collects processed pixels, which arrive block-by-block, each block in raster order, into an M-row stripe buffer. Streams the stripe back out in full-image raster order over a valid/ready handshake. A complete image is the concatenation of its stripes.

## Interface
- Data_Depth, 8, pixel width in bits
- Max_M, 72, largest block side
- Max_N, 720, largest image width in pixels
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-low
- cfg_load  in  1  one-cycle strobe; latches cfg_M/cfg_N
- cfg_M  in  8  block side M
- cfg_N  in  10  image width N
- Pixel_Data  in  Data_Depth  processed pixel
- new_pixel  in  1  one-cycle strobe, Pixel_Data valid; no backpressure
- out_pixel  out  Data_Depth  raster-order pixel
- out_valid  out  1  out_pixel valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_eol  out  1  qualifies last pixel of an image row
- out_eos  out  1  qualifies last pixel of a stripe
- cfg_err  out  1  sticky, last cfg_load rejected
- overflow  out  1  sticky, a new_pixel was dropped
- busy  out  1  any bank full/filling or drain in progress

## Operation
- Reset: all outputs 0. Banks are empty. The block is unconfigured (W_IDLE).
- cfg_load accepted only when busy=0 and no write counter is mid-stripe; otherwise it is ignored with no flag change.
- A config is rejected (cfg_err=1, stay W_IDLE) if M=0, M>Max_M, N=0, N>Max_N, or N mod M≠0.
- A valid config clears cfg_err and overflow and enters W_FILL.
- Write counters: col c (0..M-1), row r (0..M-1), block k (0..N/M-1). Address = r·N + k·M + c. It is kept incrementally by adding row_base (r·N) and blk_base (k·M); no divider.
- Per new_pixel: write to the current bank at that address, then c++. On c wrap, r++. On r wrap, k++. On k wrap the bank is marked full and the write side switches banks.
- Write FSM: W_IDLE → W_FILL on valid config. W_FILL → W_WAIT when the next bank is still full. W_WAIT → W_FILL when that bank is freed.
- new_pixel in W_IDLE or W_WAIT: pixel dropped, overflow=1.
- Read FSM:
  - R_IDLE → R_DRAIN when the oldest bank is full.
  - R_DRAIN reads addresses 0..M·N-1 sequentially.
  - After the last handshake, the bank is freed and the FSM returns to R_IDLE.
  - If the other bank is already full, R_DRAIN re-enters directly.
- out_eol when (addr+1) mod N = 0. out_eos at addr = M·N-1.
- Width rules: addresses are ceil(log2(Max_M·Max_N)) = 16 bits. Products are computed by accumulation only.

## Timing
- RAM read latency is 1 cycle, followed by an output register.
- First out_valid appears 2 cycles after the bank-full flag rises.
- Sustains 1 pixel/cycle while out_ready=1.
- When out_valid=1 && out_ready=0, out_pixel, out_eol and out_eos hold stable. out_valid stays high until the handshake.
- The write side accepts a new_pixel every cycle. A write and a read to different banks in the same cycle are always legal.
- Bank-full rising on the same cycle the other bank's last handshake occurs: the drain starts the following cycle, with no extra bubble beyond RAM latency.
- rst low mid-stripe: the next edge restores the reset state. Partial stripe data is discarded, out_valid=0, and the block is unconfigured.

## Configuration
- PINGPONG_EN defined: two banks of Max_M·Max_N words, so filling overlaps draining.
- PINGPONG_EN undefined: one bank. The write side is in W_WAIT for the entire drain, and any new_pixel arriving during a drain sets overflow.

## Structure
- Package block_pkg:
  - MAX_M, MAX_N, DATA_DEPTH
  - ADDR_W=16
  - write/read state enums
  - config-validity function
- Sub-module stripe_ram: simple dual-port, one write port, one registered read port, depth MAX_M·MAX_N. Instantiated once per bank.

## Test plan
- M=2, N=4, pixels 0..7 streamed (block0=0..3, block1=4..7), out_ready=1 → output 0,1,4,5,2,3,6,7; out_eol on 5 and 7; out_eos on 7.
- Same stream, out_ready toggling 1,0,0,1… → identical sequence, and out_pixel stable across every stalled cycle.
- PINGPONG_EN, M=2, N=4, two stripes back-to-back with out_ready=0 until both are written → overflow=0; the second stripe (8..15) drains as 8,9,12,13,10,11,14,15.
- Config: cfg_M=3, cfg_N=8 → cfg_err=1, busy=0, and a following new_pixel sets overflow. Then cfg_M=2, cfg_N=8 → both flags clear.
- rst low after 3 pixels of a stripe, then reconfigure M=2, N=4 and send 0..7 → clean output matching test 1, with no stale data.
- Without PINGPONG_EN: new_pixel during a drain → overflow=1, and the drained stripe data is unaffected.

Source files
------------

// File: rtl/block_pkg.sv
// ---------------------------------------------------------------------------
// block_pkg
// Shared constants, FSM state types and the configuration-validity check for
// the block reassembler and its stripe buffer RAM.
//   DATA_DEPTH : pixel width in bits
//   MAX_M      : largest block side
//   MAX_N      : largest image width in pixels
//   ADDR_W     : stripe buffer address width (covers MAX_M*MAX_N words)
// ---------------------------------------------------------------------------
package block_pkg;

    localparam int unsigned DATA_DEPTH = 8;
    localparam int unsigned MAX_M      = 72;
    localparam int unsigned MAX_N      = 720;
    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned RAM_DEPTH  = MAX_M * MAX_N;
    localparam int unsigned M_W        = 8;
    localparam int unsigned N_W        = 10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_WAIT = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE  = 1'b0,
        R_DRAIN = 1'b1
    } rd_state_t;

    // A geometry is usable when both sides are in range and the image width
    // is a whole number of blocks.
    function automatic logic cfg_valid(input logic [M_W-1:0] m,
                                       input logic [N_W-1:0] n);
        logic ok;
        ok = (m != '0) && (32'(m) <= MAX_M) && (n != '0) && (32'(n) <= MAX_N);
        if (ok) begin
            ok = ((n % N_W'(m)) == '0);
        end
        return ok;
    endfunction

endpackage

// File: rtl/stripe_ram.sv
// ---------------------------------------------------------------------------
// stripe_ram
// Simple dual-port stripe buffer: one write port, one registered read port.
// The read register only updates when re_i is high, so it holds its word
// while the downstream pipeline is stalled.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   re_i    : read enable (loads the read register)
//   raddr_i : read address
//   rdata_o : registered read data, one cycle after re_i
// ---------------------------------------------------------------------------
module stripe_ram #(
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 16,
    parameter int unsigned DEPTH = 51840
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/block_reassembler.sv
// ---------------------------------------------------------------------------
// block_reassembler
// Collects block-ordered pixels into an M-row stripe buffer and streams the
// stripe back out in image raster order over a valid/ready handshake.
//
// Build option: PINGPONG_EN defined -> two stripe banks, filling overlaps
// draining. Undefined -> one bank, writes are refused for the whole drain.
//
// Ports:
//   clk        : clock, all logic on rising edge
//   rst        : synchronous active-low reset
//   cfg_load   : strobe latching cfg_M / cfg_N
//   cfg_M      : block side M
//   cfg_N      : image width N
//   Pixel_Data : processed pixel, valid with new_pixel
//   new_pixel  : pixel strobe, no backpressure
//   out_pixel  : raster-order pixel
//   out_valid  : out_pixel valid
//   out_ready  : consumer ready
//   out_eol    : last pixel of an image row
//   out_eos    : last pixel of a stripe
//   cfg_err    : sticky, last cfg_load rejected
//   overflow   : sticky, a pixel was dropped
//   busy       : a bank is full or filling, or a drain is in progress
// ---------------------------------------------------------------------------
module block_reassembler
    import block_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_load,
    input  logic [M_W-1:0]        cfg_M,
    input  logic [N_W-1:0]        cfg_N,
    input  logic [DATA_DEPTH-1:0] Pixel_Data,
    input  logic                  new_pixel,
    output logic [DATA_DEPTH-1:0] out_pixel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_eol,
    output logic                  out_eos,
    output logic                  cfg_err,
    output logic                  overflow,
    output logic                  busy
);

`ifdef PINGPONG_EN
    localparam logic        PP_TOGGLE = 1'b1;
    localparam int unsigned NB        = 2;
`else
    localparam logic        PP_TOGGLE = 1'b0;
    localparam int unsigned NB        = 1;
`endif

    // Write side
    wr_state_t       wr_state_q, wr_state_d;
    logic [M_W-1:0]  m_q, m_d;
    logic [N_W-1:0]  n_q, n_d;
    logic            cfg_err_q, cfg_err_d;
    logic            overflow_q, overflow_d;
    logic            wr_bank_q, wr_bank_d;
    logic [M_W-1:0]  c_q, c_d;
    logic [M_W-1:0]  r_q, r_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] blk_base_q, blk_base_d;
    logic [1:0]      full_q, full_d;

    // Read side
    rd_state_t       rd_state_q, rd_state_d;
    logic            rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [N_W-1:0]  rd_col_q, rd_col_d;
    logic [M_W-1:0]  rd_row_q, rd_row_d;
    logic            iss_pend_q, iss_pend_d;
    logic            s1_v_q, s1_v_d;
    logic            s1_eol_q, s1_eol_d;
    logic            s1_eos_q, s1_eos_d;
    logic            s1_bank_q, s1_bank_d;
    logic [DATA_DEPTH-1:0] out_pixel_q, out_pixel_d;
    logic            out_valid_q, out_valid_d;
    logic            out_eol_q, out_eol_d;
    logic            out_eos_q, out_eos_d;

    logic [DATA_DEPTH-1:0] bank_rdata [2];
    logic [ADDR_W-1:0]     waddr;
    logic [M_W-1:0]        m_last;
    logic                  blk_last, wr_en, stripe_done, mid_stripe, busy_w;
    logic                  advance, iss_go, rd_eol_w, rd_eos_w, last_hs;

    assign m_last      = m_q - 8'd1;
    assign waddr       = row_base_q + blk_base_q + 16'(c_q);
    assign blk_last    = (blk_base_q + 16'(m_q)) == 16'(n_q);
    assign wr_en       = (wr_state_q == W_FILL) && new_pixel;
    assign stripe_done = wr_en && (c_q == m_last) && (r_q == m_last) && blk_last;
    assign mid_stripe  = (c_q != '0) || (r_q != '0) || (blk_base_q != '0);
    assign busy_w      = (|full_q) || (rd_state_q == R_DRAIN) || s1_v_q ||
                         out_valid_q || mid_stripe;

    // Whole read pipeline (RAM register + output register) moves together.
    assign advance  = !out_valid_q || out_ready;
    assign iss_go   = advance &&
                      (((rd_state_q == R_IDLE) && full_q[rd_bank_q]) ||
                       ((rd_state_q == R_DRAIN) && iss_pend_q));
    assign rd_eol_w = (rd_col_q == (n_q - 10'd1));
    assign rd_eos_w = rd_eol_w && (rd_row_q == m_last);
    assign last_hs  = out_valid_q && out_ready && out_eos_q;

    for (genvar b = 0; b < NB; b++) begin : g_bank
        stripe_ram #(
            .DW    (DATA_DEPTH),
            .AW    (ADDR_W),
            .DEPTH (RAM_DEPTH)
        ) u_ram (
            .clk_i   (clk),
            .we_i    (wr_en && (wr_bank_q == 1'(b))),
            .waddr_i (waddr),
            .wdata_i (Pixel_Data),
            .re_i    (iss_go && (rd_bank_q == 1'(b))),
            .raddr_i (raddr_q),
            .rdata_o (bank_rdata[b])
        );
    end
`ifndef PINGPONG_EN
    assign bank_rdata[1] = '0;
`endif

    always_comb begin
        wr_state_d = wr_state_q;
        m_d        = m_q;
        n_d        = n_q;
        cfg_err_d  = cfg_err_q;
        overflow_d = overflow_q;
        wr_bank_d  = wr_bank_q;
        c_d        = c_q;
        r_d        = r_q;
        row_base_d = row_base_q;
        blk_base_d = blk_base_q;

        // Bank ownership: freed on the last output handshake, claimed when
        // the write side finishes a stripe.
        full_d = full_q;
        if (last_hs) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (stripe_done) begin
            full_d[wr_bank_q] = 1'b1;
        end

        unique case (wr_state_q)
            W_IDLE: ;
            W_FILL: begin
                if (new_pixel) begin
                    if (c_q == m_last) begin
                        c_d = '0;
                        if (r_q == m_last) begin
                            r_d        = '0;
                            row_base_d = '0;
                            if (blk_last) begin
                                blk_base_d = '0;
                                wr_bank_d  = wr_bank_q ^ PP_TOGGLE;
                                // Looking at full_d lets a bank freed this very
                                // cycle be refilled without a dropped pixel.
                                wr_state_d = full_d[wr_bank_q ^ PP_TOGGLE] ? W_WAIT : W_FILL;
                            end else begin
                                blk_base_d = blk_base_q + 16'(m_q);
                            end
                        end else begin
                            r_d        = r_q + 8'd1;
                            row_base_d = row_base_q + 16'(n_q);
                        end
                    end else begin
                        c_d = c_q + 8'd1;
                    end
                end
            end
            W_WAIT: begin
                if (!full_d[wr_bank_q]) begin
                    wr_state_d = W_FILL;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase

        if (new_pixel && (wr_state_q != W_FILL)) begin
            overflow_d = 1'b1;
        end

        if (cfg_load && !busy_w) begin
            c_d        = '0;
            r_d        = '0;
            row_base_d = '0;
            blk_base_d = '0;
            if (cfg_valid(cfg_M, cfg_N)) begin
                m_d        = cfg_M;
                n_d        = cfg_N;
                cfg_err_d  = 1'b0;
                overflow_d = 1'b0;
                wr_state_d = W_FILL;
            end else begin
                cfg_err_d  = 1'b1;
                wr_state_d = W_IDLE;
            end
        end
    end

    always_comb begin
        rd_state_d  = rd_state_q;
        rd_bank_d   = rd_bank_q;
        raddr_d     = raddr_q;
        rd_col_d    = rd_col_q;
        rd_row_d    = rd_row_q;
        iss_pend_d  = iss_pend_q;
        s1_v_d      = s1_v_q;
        s1_eol_d    = s1_eol_q;
        s1_eos_d    = s1_eos_q;
        s1_bank_d   = s1_bank_q;
        out_pixel_d = out_pixel_q;
        out_valid_d = out_valid_q;
        out_eol_d   = out_eol_q;
        out_eos_d   = out_eos_q;

        if (iss_go) begin
            rd_state_d = R_DRAIN;
            raddr_d    = raddr_q + 16'd1;
            iss_pend_d = !rd_eos_w;
            if (rd_eol_w) begin
                rd_col_d = '0;
                rd_row_d = rd_row_q + 8'd1;
            end else begin
                rd_col_d = rd_col_q + 10'd1;
            end
        end

        if (advance) begin
            s1_v_d      = iss_go;
            s1_eol_d    = iss_go && rd_eol_w;
            s1_eos_d    = iss_go && rd_eos_w;
            s1_bank_d   = rd_bank_q;
            out_valid_d = s1_v_q;
            out_eol_d   = s1_v_q && s1_eol_q;
            out_eos_d   = s1_v_q && s1_eos_q;
            if (s1_v_q) begin
                out_pixel_d = bank_rdata[s1_bank_q];
            end
        end

        if (last_hs) begin
            rd_state_d = R_IDLE;
            rd_bank_d  = rd_bank_q ^ PP_TOGGLE;
            raddr_d    = '0;
            rd_col_d   = '0;
            rd_row_d   = '0;
            iss_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_state_q  <= W_IDLE;
            m_q         <= '0;
            n_q         <= '0;
            cfg_err_q   <= 1'b0;
            overflow_q  <= 1'b0;
            wr_bank_q   <= 1'b0;
            c_q         <= '0;
            r_q         <= '0;
            row_base_q  <= '0;
            blk_base_q  <= '0;
            full_q      <= '0;
            rd_state_q  <= R_IDLE;
            rd_bank_q   <= 1'b0;
            raddr_q     <= '0;
            rd_col_q    <= '0;
            rd_row_q    <= '0;
            iss_pend_q  <= 1'b0;
            s1_v_q      <= 1'b0;
            s1_eol_q    <= 1'b0;
            s1_eos_q    <= 1'b0;
            s1_bank_q   <= 1'b0;
            out_pixel_q <= '0;
            out_valid_q <= 1'b0;
            out_eol_q   <= 1'b0;
            out_eos_q   <= 1'b0;
        end else begin
            wr_state_q  <= wr_state_d;
            m_q         <= m_d;
            n_q         <= n_d;
            cfg_err_q   <= cfg_err_d;
            overflow_q  <= overflow_d;
            wr_bank_q   <= wr_bank_d;
            c_q         <= c_d;
            r_q         <= r_d;
            row_base_q  <= row_base_d;
            blk_base_q  <= blk_base_d;
            full_q      <= full_d;
            rd_state_q  <= rd_state_d;
            rd_bank_q   <= rd_bank_d;
            raddr_q     <= raddr_d;
            rd_col_q    <= rd_col_d;
            rd_row_q    <= rd_row_d;
            iss_pend_q  <= iss_pend_d;
            s1_v_q      <= s1_v_d;
            s1_eol_q    <= s1_eol_d;
            s1_eos_q    <= s1_eos_d;
            s1_bank_q   <= s1_bank_d;
            out_pixel_q <= out_pixel_d;
            out_valid_q <= out_valid_d;
            out_eol_q   <= out_eol_d;
            out_eos_q   <= out_eos_d;
        end
    end

    assign out_pixel = out_pixel_q;
    assign out_valid = out_valid_q;
    assign out_eol   = out_eol_q;
    assign out_eos   = out_eos_q;
    assign cfg_err   = cfg_err_q;
    assign overflow  = overflow_q;
    assign busy      = busy_w;

endmodule

// File: tb/tb_block_reassembler.sv
// ---------------------------------------------------------------------------
// tb_block_reassembler
// Directed and randomized checks of block_reassembler against a raster-order
// reference model built from the block/row/column arrival order.
// ---------------------------------------------------------------------------
module tb_block_reassembler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_M = '0;
    logic [9:0] cfg_N = '0;
    logic [7:0] Pixel_Data = '0;
    logic       new_pixel = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_pixel;
    logic       out_valid, out_eol, out_eos, cfg_err, overflow, busy;

    block_reassembler dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_load   (cfg_load),
        .cfg_M      (cfg_M),
        .cfg_N      (cfg_N),
        .Pixel_Data (Pixel_Data),
        .new_pixel  (new_pixel),
        .out_pixel  (out_pixel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_eol    (out_eol),
        .out_eos    (out_eos),
        .cfg_err    (cfg_err),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned fails   = 0;
    int          rdy_mode = 0;   // 0 always, 1 pattern 1,0,0, 2 random, 3 never
    int          cyc = 0;
    int          first_valid_cyc = -1;
    logic        prev_stall = 1'b0;
    logic [7:0]  pix_buf [$];
    logic [7:0]  exp_pix [$];
    logic        exp_eol [$];
    logic        exp_eos [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance.
    task automatic step(input logic np, input logic [7:0] pix);
        logic rdy;
        case (rdy_mode)
            0:       rdy = 1'b1;
            1:       rdy = ((cyc % 3) == 0);
            2:       rdy = ($urandom_range(0, 3) != 0);
            default: rdy = 1'b0;
        endcase
        new_pixel  = np;
        Pixel_Data = pix;
        out_ready  = rdy;
        @(negedge clk);
        if (prev_stall) check("valid_held", 32'(out_valid), 32'd1);
        if (out_valid) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (exp_pix.size() == 0) begin
                check("unexpected_valid", 32'(out_valid), 32'd0);
            end else begin
                check("out_pixel", 32'(out_pixel), 32'(exp_pix[0]));
                check("out_eol", 32'(out_eol), 32'(exp_eol[0]));
                check("out_eos", 32'(out_eos), 32'(exp_eos[0]));
                if (out_ready) begin
                    void'(exp_pix.pop_front());
                    void'(exp_eol.pop_front());
                    void'(exp_eos.pop_front());
                end
            end
        end
        prev_stall = out_valid && !out_ready;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Raster order of a stripe whose pixels arrived block by block.
    task automatic push_expected(input int m, input int n);
        for (int r = 0; r < m; r++) begin
            for (int x = 0; x < n; x++) begin
                int idx;
                idx = ((x / m) * m + r) * m + (x % m);
                exp_pix.push_back(pix_buf[idx]);
                exp_eol.push_back(x == n - 1);
                exp_eos.push_back((x == n - 1) && (r == m - 1));
            end
        end
    endtask

    task automatic send(input int m, input int n, input int start, input bit rnd, input bit gaps);
        pix_buf.delete();
        for (int i = 0; i < m * n; i++) begin
            logic [7:0] p;
            p = rnd ? 8'($urandom_range(0, 255)) : 8'(start + i);
            if (gaps && ($urandom_range(0, 3) == 0)) step(1'b0, 8'd0);
            pix_buf.push_back(p);
            step(1'b1, p);
        end
        push_expected(m, n);
    endtask

    task automatic drain(input int budget);
        int b;
        b = 0;
        while (exp_pix.size() != 0 && b < budget) begin
            step(1'b0, 8'd0);
            b++;
        end
        check("drain_done", 32'(exp_pix.size()), 32'd0);
        repeat (3) step(1'b0, 8'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic configure(input int m, input int n);
        cfg_M    = 8'(m);
        cfg_N    = 10'(n);
        cfg_load = 1'b1;
        step(1'b0, 8'd0);
        cfg_load = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        new_pixel = 1'b0;
        cfg_load  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc++;
        prev_stall = 1'b0;
        exp_pix.delete();
        exp_eol.delete();
        exp_eos.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_pixel"}, 32'(out_pixel), 32'd0);
        check({tag, "_eol"}, 32'(out_eol), 32'd0);
        check({tag, "_eos"}, 32'(out_eos), 32'd0);
        check({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int w_cyc;
        int bm [4] = '{1, 1, 72, 8};
        int bn [4] = '{1, 720, 72, 8};

        do_reset();
        check_reset_state("reset");

        // Basic stripe, always ready, plus first-output latency.
        rdy_mode = 0;
        configure(2, 4);
        check("cfg_ok_err", 32'(cfg_err), 32'd0);
        first_valid_cyc = -1;
        send(2, 4, 0, 1'b0, 1'b0);
        w_cyc = cyc - 1;
        drain(200);
        check("first_valid_latency", 32'(first_valid_cyc - w_cyc), 32'd3);

        // Same stream under 1,0,0 backpressure.
        rdy_mode = 1;
        send(2, 4, 0, 1'b0, 1'b0);
        drain(200);

        // Rejected geometry, then a good one.
        rdy_mode = 0;
        configure(3, 8);
        check("bad_cfg_err", 32'(cfg_err), 32'd1);
        check("bad_cfg_busy", 32'(busy), 32'd0);
        step(1'b1, 8'h55);
        check("unconfigured_overflow", 32'(overflow), 32'd1);
        configure(2, 8);
        check("good_cfg_err", 32'(cfg_err), 32'd0);
        check("good_cfg_overflow", 32'(overflow), 32'd0);

        // Reset mid-stripe; a cfg_load mid-stripe is ignored.
        configure(2, 4);
        step(1'b1, 8'hA0);
        step(1'b1, 8'hA1);
        step(1'b1, 8'hA2);
        check("mid_busy", 32'(busy), 32'd1);
        configure(3, 8);
        check("mid_cfg_ignored", 32'(cfg_err), 32'd0);
        do_reset();
        check_reset_state("mid_reset");
        step(1'b1, 8'h11);
        check("post_reset_unconfigured", 32'(overflow), 32'd1);
        configure(2, 4);
        send(2, 4, 0, 1'b0, 1'b0);
        drain(200);

`ifdef PINGPONG_EN
        // Two stripes written back-to-back before any output is taken.
        rdy_mode = 3;
        send(2, 4, 0, 1'b0, 1'b0);
        send(2, 4, 8, 1'b0, 1'b0);
        check("pp_overflow", 32'(overflow), 32'd0);
        rdy_mode = 0;
        drain(200);
`else
        // Pixel arriving while the only bank is draining.
        rdy_mode = 3;
        send(2, 4, 100, 1'b0, 1'b0);
        repeat (2) step(1'b0, 8'd0);
        step(1'b1, 8'hC8);
        check("drain_overflow", 32'(overflow), 32'd1);
        rdy_mode = 0;
        drain(200);
        check("overflow_sticky", 32'(overflow), 32'd1);
`endif

        // Random geometry acceptance.
        for (int i = 0; i < 16; i++) begin
            int m, n;
            bit ok;
            m = $urandom_range(0, 80);
            n = $urandom_range(0, 730);
            if ($urandom_range(0, 1) == 1) n = m * $urandom_range(1, 10);
            ok = (m >= 1) && (m <= 72) && (n >= 1) && (n <= 720) && (m != 0 && n % m == 0);
            configure(m, n);
            check("rand_cfg_err", 32'(cfg_err), 32'(!ok));
            check("rand_cfg_busy", 32'(busy), 32'd0);
        end

        // Boundary geometries, random data and backpressure.
        rdy_mode = 2;
        for (int i = 0; i < 4; i++) begin
            configure(bm[i], bn[i]);
            check("bnd_cfg_err", 32'(cfg_err), 32'd0);
            send(bm[i], bn[i], 0, 1'b1, 1'b0);
            drain(4 * bm[i] * bn[i] + 100);
        end

        // Random small geometries with write gaps.
        for (int i = 0; i < 6; i++) begin
            int m, n;
            m = $urandom_range(1, 8);
            n = m * $urandom_range(1, 4);
            configure(m, n);
            check("rnd_cfg_err", 32'(cfg_err), 32'd0);
            send(m, n, 0, 1'b1, 1'b1);
            drain(4 * m * n + 100);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
